// File: rtl/updown_sched.sv
// updown_sched: round-robin, hold-bounded scheduler stepping one saturating up/down counter.
// Optional UPDOWN_SCHED_SAT_RELEASE_EN: a saturated owner releases instead of stepping.
module updown_sched #(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_up_i,
  input  logic             req_dn_i,
  input  logic             clr_i,
  output logic             gnt_up_o,
  output logic             gnt_dn_o,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_hi_o,
  output logic             sat_lo_o,
  output logic             busy_o
);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};
  localparam logic [HW-1:0] HLAST = HW'(MAX_HOLD - 1);
  typedef enum logic [1:0] {IDLE, SERVE_UP, SERVE_DN} state_t;
  state_t state_q, state_d, oth_state;
  logic [WIDTH-1:0] count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;
  logic last_q, last_d;
  logic dir_dn, own_req, oth_req, sat_own, step, up_ok, dn_ok;
  assign sat_hi_o = count_q == CMAX;
  assign sat_lo_o = count_q == '0;
  assign gnt_up_o = state_q == SERVE_UP;
  assign gnt_dn_o = state_q == SERVE_DN;
  assign busy_o   = gnt_up_o | gnt_dn_o;
  assign count_o  = count_q;
  // Work relative to the current owner so both serve states share one path.
  assign dir_dn    = state_q == SERVE_DN;
  assign own_req   = dir_dn ? req_dn_i : req_up_i;
  assign oth_req   = dir_dn ? req_up_i : req_dn_i;
  assign sat_own   = dir_dn ? sat_lo_o : sat_hi_o;
  assign oth_state = dir_dn ? SERVE_UP : SERVE_DN;
`ifdef UPDOWN_SCHED_SAT_RELEASE_EN
  assign step  = own_req & ~sat_own;
  assign up_ok = req_up_i & ~sat_hi_o;
  assign dn_ok = req_dn_i & ~sat_lo_o;
`else
  assign step  = own_req;
  assign up_ok = req_up_i;
  assign dn_ok = req_dn_i;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      state_d = (up_ok && (!dn_ok || last_q)) ? SERVE_UP : dn_ok ? SERVE_DN : IDLE;
    end else if (step) begin
      count_d = sat_own ? count_q : dir_dn ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
      hold_d  = (hold_q == HLAST) ? '0 : hold_q + HW'(1);
      if (hold_q == HLAST && oth_req) begin
        state_d = oth_state;
        last_d  = dir_dn;
      end
    end else begin
      hold_d  = '0;
      last_d  = dir_dn;
      state_d = oth_req ? oth_state : IDLE;
    end
    if (clr_i) count_d = '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      hold_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end
endmodule
